// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM controller slice: command encodings in
// {cs_n, ras_n, cas_n, we_n} order, the address/bank values driven while the
// bus is idle, and the one-hot arbiter state encoding.
// -----------------------------------------------------------------------------
package sdram_pkg;

  // SDRAM commands, {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] NOP       = 4'b0111;
  localparam logic [3:0] PRE_CHA   = 4'b0010;
  localparam logic [3:0] ACTIVE    = 4'b0011;
  localparam logic [3:0] WRITE_CMD = 4'b0100;
  localparam logic [3:0] READ_CMD  = 4'b0101;
  localparam logic [3:0] AREF_CMD  = 4'b0001;
  localparam logic [3:0] BURST_TER = 4'b0110;

  // Bank/address parked on the pins while nobody owns the bus
  localparam logic [1:0]  IDLE_BA   = 2'b11;
  localparam logic [12:0] IDLE_ADDR = 13'h1fff;

  // One-hot arbiter states
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_AREF  = 5'b00100,
    S_WRITE = 5'b01000,
    S_READ  = 5'b10000
  } arb_state_e;

endpackage : sdram_pkg

// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
// Command arbiter between the SDRAM init, auto-refresh, write and read
// sub-controllers. Init owns the pins until init_end; afterwards one
// controller at a time is granted with fixed priority refresh > write > read,
// and every grant is separated by a single ARBIT cycle that drives NOP.
//
// Ports:
//   sys_clk, sys_rst_n            clock, async active-low reset
//   init_*                        init controller command/bank/address, init_end
//   aref_*, wr_*, rd_*            request level, done pulse, cmd/ba/addr
//   wr_sdram_en/wr_sdram_data     write data and its valid, put on DQ
//   aref_en, wr_en, rd_en         grants (decoded from state)
//   sdram_cke..sdram_addr         SDRAM command pins (combinational mux)
//   sdram_dq                      bidirectional data bus
// -----------------------------------------------------------------------------
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_sdram_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_sdram_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DATA_W-1:0] sdram_dq
);

  arb_state_e          r_state;
  arb_state_e          w_next;
  logic [3:0]          w_cmd;
  logic [BA_W-1:0]     w_ba;
  logic [ADDR_W-1:0]   w_addr;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: priority pick in ARBIT, each service ends only on its own *_end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (init_end) w_next = S_ARBIT;
        else          w_next = S_IDLE;
      end
      S_ARBIT: begin
        if (aref_req)    w_next = S_AREF;
        else if (wr_req) w_next = S_WRITE;
        else if (rd_req) w_next = S_READ;
        else             w_next = S_ARBIT;
      end
      S_AREF: begin
        if (aref_end) w_next = S_ARBIT;
        else          w_next = S_AREF;
      end
      S_WRITE: begin
        if (wr_end) w_next = S_ARBIT;
        else        w_next = S_WRITE;
      end
      S_READ: begin
        if (rd_end) w_next = S_ARBIT;
        else        w_next = S_READ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pin mux: sub-controllers already register their outputs, so no stage here
  always_comb begin
    w_cmd  = NOP;
    w_ba   = BA_W'(IDLE_BA);
    w_addr = ADDR_W'(IDLE_ADDR);
    case (r_state)
      S_IDLE: begin
        w_cmd  = init_cmd;
        w_ba   = init_ba;
        w_addr = init_addr;
      end
      S_AREF: begin
        w_cmd  = aref_cmd;
        w_ba   = aref_ba;
        w_addr = aref_addr;
      end
      S_WRITE: begin
        w_cmd  = wr_cmd;
        w_ba   = wr_ba;
        w_addr = wr_sdram_addr;
      end
      S_READ: begin
        w_cmd  = rd_cmd;
        w_ba   = rd_ba;
        w_addr = rd_sdram_addr;
      end
      default: begin
        w_cmd  = NOP;
        w_ba   = BA_W'(IDLE_BA);
        w_addr = ADDR_W'(IDLE_ADDR);
      end
    endcase
  end

  assign aref_en = (r_state == S_AREF);
  assign wr_en   = (r_state == S_WRITE);
  assign rd_en   = (r_state == S_READ);

  assign sdram_cke   = 1'b1;
  assign sdram_cs_n  = w_cmd[3];
  assign sdram_ras_n = w_cmd[2];
  assign sdram_cas_n = w_cmd[1];
  assign sdram_we_n  = w_cmd[0];
  assign sdram_ba    = w_ba;
  assign sdram_addr  = w_addr;

  // Reset gates the driver so the bus releases at once even if the write
  // controller's data-valid is still high when reset hits.
  assign sdram_dq = (sys_rst_n && wr_sdram_en) ? wr_sdram_data : {DATA_W{1'bz}};

endmodule : sdram_arbit

// File: tb/tb_sdram_arbit.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbit
// Directed bench for sdram_arbit. A bus-ownership model tracks who holds the
// SDRAM pins; a compare process checks every falling edge, and the stimulus
// sequence adds hand-computed literal checks at key points.
// DQ has a weak pull-up so a released bus reads as 16'hffff.
// -----------------------------------------------------------------------------
module tb_sdram_arbit;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = 4'b0010;
  logic [1:0]  init_ba = 2'b00;
  logic [12:0] init_addr = 13'h0400;
  logic        aref_req = 1'b0, aref_end = 1'b0;
  logic [3:0]  aref_cmd = 4'b0001;
  logic [1:0]  aref_ba = 2'b01;
  logic [12:0] aref_addr = 13'h0011;
  logic        wr_req = 1'b0, wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'b0100;
  logic [1:0]  wr_ba = 2'b10;
  logic [12:0] wr_sdram_addr = 13'h0123;
  logic        wr_sdram_en = 1'b0;
  logic [15:0] wr_sdram_data = 16'h0000;
  logic        rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'b0101;
  logic [1:0]  rd_ba = 2'b01;
  logic [12:0] rd_sdram_addr = 13'h0456;
  logic        aref_en, wr_en, rd_en;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  wire  [15:0] sdram_dq;

  int total = 0;
  int bad = 0;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (sdram_dq[g]);
  end

  always #5 sys_clk = ~sys_clk;

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
    .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
    .wr_sdram_addr(wr_sdram_addr), .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba),
    .rd_sdram_addr(rd_sdram_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
  );

  // ---------------- model: who owns the pins ----------------
  localparam int O_INIT = 0;  // before init_end: init drives the pins
  localparam int O_GAP  = 1;  // nobody granted, pins parked at NOP
  localparam int O_AREF = 2;
  localparam int O_WR   = 3;
  localparam int O_RD   = 4;

  int owner = O_INIT;

  // a finished owner hands back to the gap; a gap picks the most urgent requester
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) owner <= O_INIT;
    else if (owner == O_INIT) owner <= init_end ? O_GAP : O_INIT;
    else if (owner == O_GAP)
      owner <= aref_req ? O_AREF : (wr_req ? O_WR : (rd_req ? O_RD : O_GAP));
    else if ((owner == O_AREF && aref_end) || (owner == O_WR && wr_end) ||
             (owner == O_RD && rd_end))
      owner <= O_GAP;
  end

  function automatic logic [2:0] exp_grants(int o);
    return {o == O_AREF, o == O_WR, o == O_RD};
  endfunction

  function automatic logic [18:0] exp_pins(int o);  // {cmd, ba, addr}
    if (o == O_INIT) return {init_cmd, init_ba, init_addr};
    if (o == O_AREF) return {aref_cmd, aref_ba, aref_addr};
    if (o == O_WR)   return {wr_cmd, wr_ba, wr_sdram_addr};
    if (o == O_RD)   return {rd_cmd, rd_ba, rd_sdram_addr};
    return {4'b0111, 2'b11, 13'h1fff};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every falling edge
  always @(negedge sys_clk) begin
    check("grants", {29'd0, aref_en, wr_en, rd_en}, {29'd0, exp_grants(owner)});
    check("pins", {13'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
          {13'd0, exp_pins(owner)});
    check("cke", {31'd0, sdram_cke}, 32'd1);
    check("dq", {16'd0, sdram_dq},
          {16'd0, (sys_rst_n && wr_sdram_en) ? wr_sdram_data : 16'hffff});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [31:0] cmd_now();
    return {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  endfunction

  function automatic logic [31:0] gr_now();
    return {29'd0, aref_en, wr_en, rd_en};
  endfunction

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    cyc(20);
    @(negedge sys_clk);
    check("lit_init_cmd", cmd_now(), 32'h2);
    check("lit_init_grants", gr_now(), 32'h0);
    cyc(1); init_end = 1'b1;
    cyc(1);
    @(negedge sys_clk);
    check("lit_arbit_cmd", cmd_now(), 32'h7);
    check("lit_arbit_ba", {30'd0, sdram_ba}, 32'h3);
    check("lit_arbit_addr", {19'd0, sdram_addr}, 32'h1fff);
    check("lit_arbit_grants", gr_now(), 32'h0);
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    cyc(1); aref_req = 1'b0;
    @(negedge sys_clk);
    check("lit_all_req_aref", gr_now(), 32'h4);
    cyc(2); aref_end = 1'b1;
    cyc(1); aref_end = 1'b0;
    @(negedge sys_clk);
    check("lit_gap_grants", gr_now(), 32'h0);
    check("lit_gap_cmd", cmd_now(), 32'h7);
    cyc(1);
    @(negedge sys_clk);
    check("lit_write_grant", gr_now(), 32'h2);
    check("lit_write_cmd", cmd_now(), 32'h4);
    wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5A5;
    repeat (4) begin
      @(negedge sys_clk);
      check("lit_dq_drive", {16'd0, sdram_dq}, 32'hA5A5);
    end
    wr_sdram_en = 1'b0;
    @(negedge sys_clk);
    check("lit_dq_release", {16'd0, sdram_dq}, 32'hffff);
    aref_req = 1'b1;
    cyc(2);
    @(negedge sys_clk);
    check("lit_no_preempt", gr_now(), 32'h2);
    wr_end = 1'b1; wr_req = 1'b0;
    cyc(1); wr_end = 1'b0;
    @(negedge sys_clk);
    check("lit_gap2", gr_now(), 32'h0);
    cyc(1); aref_req = 1'b0;
    @(negedge sys_clk);
    check("lit_aref_before_rd", gr_now(), 32'h4);
    aref_end = 1'b1;
    cyc(1); aref_end = 1'b0;
    cyc(1);
    @(negedge sys_clk);
    check("lit_read_grant", gr_now(), 32'h1);
    check("lit_read_cmd", cmd_now(), 32'h5);
    wr_end = 1'b1;
    cyc(1); wr_end = 1'b0;
    @(negedge sys_clk);
    check("lit_stray_wr_end", gr_now(), 32'h1);
    cyc(2); rd_end = 1'b1; rd_req = 1'b0;
    cyc(1); rd_end = 1'b0;
    cyc(3);
    @(negedge sys_clk);
    check("lit_arbit_hold", gr_now(), 32'h0);
    check("lit_arbit_hold_cmd", cmd_now(), 32'h7);
    wr_req = 1'b1;
    cyc(1);
    wr_sdram_en = 1'b1; wr_sdram_data = 16'h3C3C;
    @(negedge sys_clk);
    check("lit_dq_3c", {16'd0, sdram_dq}, 32'h3C3C);
    #2 sys_rst_n = 1'b0; init_end = 1'b0;
    #1;
    check("lit_rst_grants", gr_now(), 32'h0);
    check("lit_rst_dq", {16'd0, sdram_dq}, 32'hffff);
    check("lit_rst_cmd", cmd_now(), 32'h2);
    cyc(3);
    wr_sdram_en = 1'b0; sys_rst_n = 1'b1;
    cyc(5);
    @(negedge sys_clk);
    check("lit_wait_init", gr_now(), 32'h0);
    check("lit_wait_init_cmd", cmd_now(), 32'h2);
    init_end = 1'b1;
    cyc(2);
    @(negedge sys_clk);
    check("lit_regrant_write", gr_now(), 32'h2);
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sdram_arbit
